// File: rtl/vga_fb_fetch_arbiter_if.sv
// +--------------------------------------------------------------------+
// | vga_fb_fetch_arbiter_if: CPU bus and framebuffer memory bus bundle  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface vga_fb_fetch_arbiter_if #(
  parameter int AW = 19,
  parameter int DW = 32
) ();
  logic          cpu_cyc;
  logic          cpu_stb;
  logic          cpu_we;
  logic [AW-1:0] cpu_adr;
  logic [DW-1:0] cpu_dat_i;
  logic [DW-1:0] cpu_dat_o;
  logic          cpu_ack;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdat;
  logic [DW-1:0] mem_rdat;
  logic          mem_ack;

  // master: the arbiter (CPU bus target, memory initiator)
  modport master (
    input  cpu_cyc, cpu_stb, cpu_we, cpu_adr, cpu_dat_i,
    output cpu_dat_o, cpu_ack,
    output mem_req, mem_we, mem_adr, mem_wdat,
    input  mem_rdat, mem_ack
  );

  modport slave (
    output cpu_cyc, cpu_stb, cpu_we, cpu_adr, cpu_dat_i,
    input  cpu_dat_o, cpu_ack,
    input  mem_req, mem_we, mem_adr, mem_wdat,
    output mem_rdat, mem_ack
  );
endinterface

`default_nettype wire

// File: rtl/vga_fb_fetch_arbiter.sv
// +--------------------------------------------------------------------+
// | vga_fb_fetch_arbiter: scanline prefetch into a double-banked line   |
// | buffer, CPU accesses served in the gaps. Rev 1.0                   |
// +--------------------------------------------------------------------+
`default_nettype none

module vga_fb_fetch_arbiter #(
  parameter int            AW         = 19,
  parameter int            DW         = 32,
  parameter int            LINE_WORDS = 180,
  parameter int            LINES      = 404,
  parameter logic [AW-1:0] FB_BASE    = '0
) (
  input  logic                          clock,
  input  logic                          rst_i,
  input  logic                          eol,
  input  logic                          eos,
  vga_fb_fetch_arbiter_if.master        bus,
  output logic                          lb_we,
  output logic                          lb_bank,
  output logic [$clog2(LINE_WORDS)-1:0] lb_adr,
  output logic [DW-1:0]                 lb_dat,
  input  logic                          underrun_clr,
  output logic                          underrun
);

  localparam int BW = $clog2(LINE_WORDS);
  localparam int CW = $clog2(LINES + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_CPU     = 2'd2;
  localparam logic [1:0] S_CPU_ACK = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] line_addr_q, line_addr_d;
  logic [CW-1:0] line_cnt_q, line_cnt_d;
  logic [AW-1:0] fetch_base_q, fetch_base_d;
  logic          bank_q, bank_d;
  logic          pending_q, pending_d;
  logic [AW-1:0] cur_base_q, cur_base_d;
  logic          cur_bank_q, cur_bank_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          abort_q, abort_d;
  logic          underrun_q, underrun_d;
  logic [AW-1:0] cpu_adr_q, cpu_adr_d;
  logic          cpu_we_q, cpu_we_d;
  logic [DW-1:0] cpu_wdat_q, cpu_wdat_d;
  logic [DW-1:0] cpu_rdat_q, cpu_rdat_d;

  logic          trig_eol, trig;
  logic          mem_req, mem_we, cpu_ack, lb_we_c;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdat;

  always_comb begin
    state_d      = state_q;
    line_addr_d  = line_addr_q;
    line_cnt_d   = line_cnt_q;
    fetch_base_d = fetch_base_q;
    bank_d       = bank_q;
    pending_d    = pending_q;
    cur_base_d   = cur_base_q;
    cur_bank_d   = cur_bank_q;
    beat_d       = beat_q;
    abort_d      = abort_q;
    underrun_d   = underrun_q;
    cpu_adr_d    = cpu_adr_q;
    cpu_we_d     = cpu_we_q;
    cpu_wdat_d   = cpu_wdat_q;
    cpu_rdat_d   = cpu_rdat_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_adr      = '0;
    mem_wdat     = '0;
    cpu_ack      = 1'b0;
    lb_we_c      = 1'b0;

    trig_eol = eol & ~eos & (line_cnt_q < CW'(LINES));
    trig     = eos | trig_eol;

    if (eos) begin
      fetch_base_d = FB_BASE;
      line_addr_d  = FB_BASE + AW'(LINE_WORDS);
      line_cnt_d   = CW'(1);
      bank_d       = 1'b0;
    end else if (trig_eol) begin
      fetch_base_d = line_addr_q;
      line_addr_d  = line_addr_q + AW'(LINE_WORDS);
      line_cnt_d   = line_cnt_q + CW'(1);
      bank_d       = ~bank_q;
    end

    if (trig && (pending_q || state_q == S_FETCH)) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          state_d    = S_FETCH;
          pending_d  = 1'b0;
          beat_d     = '0;
          cur_base_d = fetch_base_q;
          cur_bank_d = bank_q;
        end else if (bus.cpu_cyc && bus.cpu_stb) begin
          state_d    = S_CPU;
          cpu_adr_d  = bus.cpu_adr;
          cpu_we_d   = bus.cpu_we;
          cpu_wdat_d = bus.cpu_dat_i;
        end
      end
      S_FETCH: begin
        mem_req = 1'b1;
        mem_adr = cur_base_q + AW'(beat_q);
        if (eos) begin
          abort_d = 1'b1;
        end
        // An aborted line lets its in-flight beat retire without a buffer write
        if (bus.mem_ack) begin
          if (abort_q || eos) begin
            state_d = S_IDLE;
            abort_d = 1'b0;
          end else begin
            lb_we_c = 1'b1;
            beat_d  = beat_q + BW'(1);
            if (beat_q == BW'(LINE_WORDS - 1)) begin
              state_d = S_IDLE;
            end
          end
        end
      end
      S_CPU: begin
        mem_req  = 1'b1;
        mem_we   = cpu_we_q;
        mem_adr  = cpu_adr_q;
        mem_wdat = cpu_wdat_q;
        if (bus.mem_ack) begin
          if (!cpu_we_q) begin
            cpu_rdat_d = bus.mem_rdat;
          end
          state_d = S_CPU_ACK;
        end
      end
      default: begin
        cpu_ack = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    if (trig) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      line_addr_q  <= FB_BASE;
      line_cnt_q   <= '0;
      fetch_base_q <= FB_BASE;
      bank_q       <= 1'b0;
      pending_q    <= 1'b0;
      cur_base_q   <= FB_BASE;
      cur_bank_q   <= 1'b0;
      beat_q       <= '0;
      abort_q      <= 1'b0;
      underrun_q   <= 1'b0;
      cpu_adr_q    <= '0;
      cpu_we_q     <= 1'b0;
      cpu_wdat_q   <= '0;
      cpu_rdat_q   <= '0;
    end else begin
      state_q      <= state_d;
      line_addr_q  <= line_addr_d;
      line_cnt_q   <= line_cnt_d;
      fetch_base_q <= fetch_base_d;
      bank_q       <= bank_d;
      pending_q    <= pending_d;
      cur_base_q   <= cur_base_d;
      cur_bank_q   <= cur_bank_d;
      beat_q       <= beat_d;
      abort_q      <= abort_d;
      underrun_q   <= underrun_d;
      cpu_adr_q    <= cpu_adr_d;
      cpu_we_q     <= cpu_we_d;
      cpu_wdat_q   <= cpu_wdat_d;
      cpu_rdat_q   <= cpu_rdat_d;
    end
  end

  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_adr   = mem_adr;
  assign bus.mem_wdat  = mem_wdat;
  assign bus.cpu_ack   = cpu_ack;
  assign bus.cpu_dat_o = cpu_rdat_q;

  assign lb_we    = lb_we_c;
  assign lb_bank  = cur_bank_q;
  assign lb_adr   = beat_q;
  assign lb_dat   = lb_we_c ? bus.mem_rdat : '0;
  assign underrun = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_fb_fetch_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_vga_fb_fetch_arbiter: directed bench for vga_fb_fetch_arbiter    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_vga_fb_fetch_arbiter;

  localparam int            AW = 19;
  localparam int            DW = 32;
  localparam int            LW = 4;
  localparam int            NL = 3;
  localparam logic [AW-1:0] BASE = 19'h100;

  logic       clock = 1'b0;
  logic       rst_i = 1'b1;
  logic       eol = 1'b0;
  logic       eos = 1'b0;
  logic       underrun_clr = 1'b0;
  logic       lb_we, lb_bank, underrun;
  logic [1:0] lb_adr;
  logic [DW-1:0] lb_dat;

  int checks = 0;
  int errors = 0;

  vga_fb_fetch_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  vga_fb_fetch_arbiter #(
    .AW(AW), .DW(DW), .LINE_WORDS(LW), .LINES(NL), .FB_BASE(BASE)
  ) dut (
    .clock(clock), .rst_i(rst_i), .eol(eol), .eos(eos), .bus(bus),
    .lb_we(lb_we), .lb_bank(lb_bank), .lb_adr(lb_adr), .lb_dat(lb_dat),
    .underrun_clr(underrun_clr), .underrun(underrun)
  );

  always #5 clock = ~clock;

  // Memory model: acknowledges each request after lat cycles
  logic [DW-1:0] mem [0:1023];
  int lat = 1;
  int cnt = 0;
  always @(posedge clock or posedge rst_i) begin
    if (rst_i) begin
      bus.mem_ack  <= 1'b0;
      bus.mem_rdat <= '0;
      cnt          <= 0;
    end else begin
      bus.mem_ack <= 1'b0;
      if (bus.mem_req && !bus.mem_ack) begin
        if (cnt + 1 >= lat) begin
          bus.mem_ack  <= 1'b1;
          bus.mem_rdat <= mem[bus.mem_adr[9:0]];
          if (bus.mem_we) mem[bus.mem_adr[9:0]] <= bus.mem_wdat;
          cnt <= 0;
        end else begin
          cnt <= cnt + 1;
        end
      end
    end
  end

  int            lb_n = 0, tx_n = 0, ack_n = 0;
  logic [1:0]    lb_adr_log  [0:63];
  logic [DW-1:0] lb_dat_log  [0:63];
  logic          lb_bank_log [0:63];
  logic [AW-1:0] tx_adr      [0:63];
  logic          tx_we       [0:63];
  always @(negedge clock) begin
    if (lb_we && lb_n < 64) begin
      lb_adr_log[lb_n]  = lb_adr;
      lb_dat_log[lb_n]  = lb_dat;
      lb_bank_log[lb_n] = lb_bank;
      lb_n++;
    end
    if (bus.mem_req && bus.mem_ack && tx_n < 64) begin
      tx_adr[tx_n] = bus.mem_adr;
      tx_we[tx_n]  = bus.mem_we;
      tx_n++;
    end
    if (bus.cpu_ack) ack_n++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_eos();
    eos = 1'b1; tick(1); eos = 1'b0;
  endtask

  task automatic pulse_eol();
    eol = 1'b1; tick(1); eol = 1'b0;
  endtask

  task automatic wait_lb(input int target, input int budget);
    int b = budget;
    while (lb_n < target && b > 0) begin tick(1); b--; end
    check("lb_wait", 128'(lb_n >= target), 128'(1));
  endtask

  task automatic do_cpu(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                        output logic [DW-1:0] rd);
    int b = 60;
    bus.cpu_cyc = 1'b1; bus.cpu_stb = 1'b1; bus.cpu_we = we;
    bus.cpu_adr = adr; bus.cpu_dat_i = dat;
    rd = '0;
    while (b > 0) begin
      tick(1);
      b--;
      if (bus.cpu_ack) begin rd = bus.cpu_dat_o; break; end
    end
    bus.cpu_cyc = 1'b0; bus.cpu_stb = 1'b0;
    check("cpu_ack_seen", 128'(b > 0), 128'(1));
    tick(4);
  endtask

  function automatic logic [127:0] outs();
    return {bus.mem_req, bus.mem_we, bus.mem_adr, bus.mem_wdat, bus.cpu_ack, bus.cpu_dat_o,
            lb_we, lb_bank, lb_adr, lb_dat, underrun};
  endfunction

  initial begin
    int L, T, A;
    logic [DW-1:0] rd;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
    bus.cpu_cyc = 1'b0; bus.cpu_stb = 1'b0; bus.cpu_we = 1'b0;
    bus.cpu_adr = '0; bus.cpu_dat_i = '0;

    tick(3);
    check("reset_outputs", outs(), 128'(0));
    rst_i = 1'b0;
    tick(2);

    // Line 0 after eos
    pulse_eos();
    wait_lb(4, 40);
    tick(3);
    for (int i = 0; i < 4; i++) begin
      check("l0_adr", 128'(lb_adr_log[i]), 128'(i));
      check("l0_dat", 128'(lb_dat_log[i]), 128'(32'hA000_0100 + i));
      check("l0_bank", 128'(lb_bank_log[i]), 128'(0));
    end
    check("l0_underrun", 128'(underrun), 128'(0));

    // Lines 1 and 2 on eol, alternating banks
    pulse_eol();
    wait_lb(8, 40);
    for (int i = 4; i < 8; i++) begin
      check("l1_adr", 128'(lb_adr_log[i]), 128'(i - 4));
      check("l1_dat", 128'(lb_dat_log[i]), 128'(32'hA000_0100 + i));
      check("l1_bank", 128'(lb_bank_log[i]), 128'(1));
    end
    pulse_eol();
    wait_lb(12, 40);
    check("l2_dat", 128'(lb_dat_log[8]), 128'(32'hA000_0108));
    check("l2_bank", 128'(lb_bank_log[8]), 128'(0));

    // Frame already has LINES lines: eol ignored
    T = tx_n;
    pulse_eol();
    tick(20);
    check("limit_lb", 128'(lb_n), 128'(12));
    check("limit_tx", 128'(tx_n), 128'(T));
    check("limit_req", 128'(bus.mem_req), 128'(0));
    check("limit_underrun", 128'(underrun), 128'(0));

    // CPU write one cycle after eos waits for the whole line
    T = tx_n;
    A = ack_n;
    pulse_eos();
    do_cpu(1'b1, 19'h10, 32'hDEAD_BEEF, rd);
    check("cpu_order_fetch", 128'(tx_adr[T + 3]), 128'(19'h103));
    check("cpu_order_adr", 128'(tx_adr[T + 4]), 128'(19'h10));
    check("cpu_order_we", 128'(tx_we[T + 4]), 128'(1));
    check("cpu_tx_count", 128'(tx_n), 128'(T + 5));
    check("cpu_ack_once", 128'(ack_n), 128'(A + 1));
    check("mem_written", 128'(mem[16]), 128'(32'hDEAD_BEEF));
    do_cpu(1'b0, 19'h10, 32'h0, rd);
    check("cpu_readback", 128'(rd), 128'(32'hDEAD_BEEF));
    check("cpu_ack_twice", 128'(ack_n), 128'(A + 2));

    // Slow memory: eol during an active fetch is an underrun
    lat = 10;
    L = lb_n;
    pulse_eos();
    tick(19);
    pulse_eol();
    check("underrun_set", 128'(underrun), 128'(1));
    wait_lb(L + 8, 300);
    check("underrun_sticky", 128'(underrun), 128'(1));
    check("ur_next_line", 128'(lb_dat_log[L + 4]), 128'(32'hA000_0104));
    check("ur_next_bank", 128'(lb_bank_log[L + 4]), 128'(1));
    tick(5);
    pulse_eol();
    wait_lb(L + 12, 200);
    check("ur_line2", 128'(lb_dat_log[L + 8]), 128'(32'hA000_0108));
    check("ur_line2_bank", 128'(lb_bank_log[L + 8]), 128'(0));
    underrun_clr = 1'b1; tick(1); underrun_clr = 1'b0;
    check("underrun_clr", 128'(underrun), 128'(0));

    // Reset in the middle of a line fetch
    lat = 1;
    tick(5);
    L = lb_n;
    pulse_eos();
    wait_lb(L + 2, 40);
    check("mid_fetch_req", 128'(bus.mem_req), 128'(1));
    rst_i = 1'b1;
    #1;
    check("rst_async_req", 128'(bus.mem_req), 128'(0));
    tick(1);
    check("rst_outputs", outs(), 128'(0));
    rst_i = 1'b0;
    tick(2);
    L = lb_n;
    T = tx_n;
    pulse_eos();
    wait_lb(L + 4, 40);
    check("restart_adr", 128'(tx_adr[T]), 128'(BASE));
    check("restart_dat", 128'(lb_dat_log[L]), 128'(32'hA000_0100));
    check("restart_bank", 128'(lb_bank_log[L]), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
